// File: rtl/ecc_scalar_pkg.sv
// ecc_scalar_pkg: shared encodings for the ECC scalar-multiplication sequencer.
// Holds the FSM state codes, the mode and op-type encodings, and the operand
// source codes used by the point-select mux.
package ecc_scalar_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SCAN    = 3'd1;
  localparam logic [2:0] ST_OP_REQ  = 3'd2;
  localparam logic [2:0] ST_OP_WAIT = 3'd3;
  localparam logic [2:0] ST_BYPASS  = 3'd4;
  localparam logic [2:0] ST_NEXT    = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam logic MODE_DA     = 1'b0;
  localparam logic MODE_LADDER = 1'b1;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_DBL = 1'b1;

  // Operand sources; in double-and-add mode the accumulator Q lives in R0.
  localparam logic [1:0] SRC_R0 = 2'd0;
  localparam logic [1:0] SRC_R1 = 2'd1;
  localparam logic [1:0] SRC_P  = 2'd2;

endpackage

// File: rtl/ecc_point_sel.sv
// ecc_point_sel: combinational operand mux over R0/R1/P plus the
// point-at-infinity bypass decision and bypass result.
module ecc_point_sel
  import ecc_scalar_pkg::*;
#(
  parameter int N = 530
) (
  input  logic [1:0]   i_sel_a,
  input  logic [1:0]   i_sel_b,
  input  logic         i_dbl,
  input  logic [N-1:0] i_r0x,
  input  logic [N-1:0] i_r0y,
  input  logic         i_r0inf,
  input  logic [N-1:0] i_r1x,
  input  logic [N-1:0] i_r1y,
  input  logic         i_r1inf,
  input  logic [N-1:0] i_px,
  input  logic [N-1:0] i_py,
  output logic [N-1:0] o_ax,
  output logic [N-1:0] o_ay,
  output logic [N-1:0] o_bx,
  output logic [N-1:0] o_by,
  output logic         o_bypass,
  output logic [N-1:0] o_byp_x,
  output logic [N-1:0] o_byp_y,
  output logic         o_byp_inf
);

  logic w_ainf;
  logic w_binf;

  // Select operand A; the base point P is never at infinity.
  always_comb begin
    o_ax   = i_r0x;
    o_ay   = i_r0y;
    w_ainf = i_r0inf;
    case (i_sel_a)
      SRC_R1: begin
        o_ax   = i_r1x;
        o_ay   = i_r1y;
        w_ainf = i_r1inf;
      end
      SRC_P: begin
        o_ax   = i_px;
        o_ay   = i_py;
        w_ainf = 1'b0;
      end
      default: ;
    endcase
  end

  // Select operand B (only meaningful for an add).
  always_comb begin
    o_bx   = i_r1x;
    o_by   = i_r1y;
    w_binf = i_r1inf;
    case (i_sel_b)
      SRC_R0: begin
        o_bx   = i_r0x;
        o_by   = i_r0y;
        w_binf = i_r0inf;
      end
      SRC_P: begin
        o_bx   = i_px;
        o_by   = i_py;
        w_binf = 1'b0;
      end
      default: ;
    endcase
  end

  // Doubling infinity stays infinity; adding infinity returns the other operand.
  always_comb begin
    o_bypass  = (i_dbl == OP_DBL) ? w_ainf : (w_ainf | w_binf);
    o_byp_x   = o_ax;
    o_byp_y   = o_ay;
    o_byp_inf = w_ainf;
    if (i_dbl == OP_ADD && w_ainf) begin
      o_byp_x   = o_bx;
      o_byp_y   = o_by;
      o_byp_inf = w_binf;
    end
  end

endmodule

// File: rtl/ecc_scalar_mult_seq.sv
// ecc_scalar_mult_seq: computes kP by double-and-add or Montgomery ladder,
// driving an external point add/double unit through a req/ack handshake.
// Optional build macro ECC_OP_COUNT_EN adds the op_count output.
module ecc_scalar_mult_seq
  import ecc_scalar_pkg::*;
#(
  parameter int N      = 530,
  parameter int K_BITS = 530
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [K_BITS-1:0] c,
  input  logic [N-1:0]      x1,
  input  logic [N-1:0]      y1,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      x3,
  output logic [N-1:0]      y3,
  output logic              inf,
  output logic              op_req,
  output logic              op_dbl,
  output logic [N-1:0]      op_xa,
  output logic [N-1:0]      op_ya,
  output logic [N-1:0]      op_xb,
  output logic [N-1:0]      op_yb,
  input  logic              op_ack,
  input  logic [N-1:0]      op_xr,
  input  logic [N-1:0]      op_yr,
  input  logic              op_inf
`ifdef ECC_OP_COUNT_EN
  ,
  output logic [15:0]       op_count
`endif
);

  localparam int IW = (K_BITS > 1) ? $clog2(K_BITS) : 1;

  logic [2:0]        r_state;
  logic [K_BITS-1:0] r_k;
  logic [N-1:0]      r_px, r_py;
  logic              r_mode;
  logic [IW-1:0]     r_idx;
  logic              r_phase, r_init, r_more;
  logic [N-1:0]      r_r0x, r_r0y, r_r1x, r_r1y;
  logic              r_r0inf, r_r1inf;
  logic              r_busy, r_done, r_inf;
  logic [N-1:0]      r_x3, r_y3;
  logic              r_op_req, r_op_dbl;
  logic [N-1:0]      r_op_xa, r_op_ya, r_op_xb, r_op_yb;

  logic              w_kbit, w_dbl, w_dst_r1, w_skip, w_last;
  logic [1:0]        w_sel_a, w_sel_b;
  logic [N-1:0]      w_ax, w_ay, w_bx, w_by;
  logic              w_bypass, w_byp_inf;
  logic [N-1:0]      w_byp_x, w_byp_y;
  logic              w_start_acc, w_ack_taken, w_wr_en;
  logic [N-1:0]      w_wr_x, w_wr_y;
  logic              w_wr_inf;

  assign w_kbit      = r_k[r_idx];
  assign w_start_acc = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_ack_taken = (r_state == ST_OP_WAIT) && op_ack;
  assign w_wr_en     = w_ack_taken || (r_state == ST_BYPASS);
  assign w_wr_x      = (r_state == ST_BYPASS) ? w_byp_x   : op_xr;
  assign w_wr_y      = (r_state == ST_BYPASS) ? w_byp_y   : op_yr;
  assign w_wr_inf    = (r_state == ST_BYPASS) ? w_byp_inf : op_inf;
  assign w_last      = r_init ? !r_more : (r_phase && r_idx == '0);

  // Describe the current step: op type, operand sources, destination, skip.
  always_comb begin
    w_dbl    = OP_DBL;
    w_sel_a  = SRC_R0;
    w_sel_b  = SRC_R1;
    w_dst_r1 = 1'b0;
    w_skip   = 1'b0;
    if (r_mode == MODE_LADDER) begin
      if (r_init) begin
        w_dst_r1 = 1'b1;
      end else if (!r_phase) begin
        w_dbl    = OP_ADD;
        w_dst_r1 = !w_kbit;
      end else begin
        w_sel_a  = w_kbit ? SRC_R1 : SRC_R0;
        w_dst_r1 = w_kbit;
      end
    end else if (r_phase) begin
      w_dbl   = OP_ADD;
      w_sel_b = SRC_P;
      w_skip  = !w_kbit;
    end
  end

  ecc_point_sel #(.N(N)) u_sel (
    .i_sel_a   (w_sel_a),
    .i_sel_b   (w_sel_b),
    .i_dbl     (w_dbl),
    .i_r0x     (r_r0x),
    .i_r0y     (r_r0y),
    .i_r0inf   (r_r0inf),
    .i_r1x     (r_r1x),
    .i_r1y     (r_r1y),
    .i_r1inf   (r_r1inf),
    .i_px      (r_px),
    .i_py      (r_py),
    .o_ax      (w_ax),
    .o_ay      (w_ay),
    .o_bx      (w_bx),
    .o_by      (w_by),
    .o_bypass  (w_bypass),
    .o_byp_x   (w_byp_x),
    .o_byp_y   (w_byp_y),
    .o_byp_inf (w_byp_inf)
  );

  // Working points: R0 seeded with P at the leading one, then op/bypass results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_r0x   <= '0;
      r_r0y   <= '0;
      r_r0inf <= 1'b0;
      r_r1x   <= '0;
      r_r1y   <= '0;
      r_r1inf <= 1'b0;
    end else if (r_state == ST_SCAN && w_kbit) begin
      r_r0x   <= r_px;
      r_r0y   <= r_py;
      r_r0inf <= 1'b0;
    end else if (w_wr_en) begin
      if (w_dst_r1) begin
        r_r1x   <= w_wr_x;
        r_r1y   <= w_wr_y;
        r_r1inf <= w_wr_inf;
      end else begin
        r_r0x   <= w_wr_x;
        r_r0y   <= w_wr_y;
        r_r0inf <= w_wr_inf;
      end
    end
  end

  // Main sequencer: scan for the leading one, then walk the steps bit by bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_k      <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_mode   <= MODE_DA;
      r_idx    <= '0;
      r_phase  <= 1'b0;
      r_init   <= 1'b0;
      r_more   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_inf    <= 1'b0;
      r_x3     <= '0;
      r_y3     <= '0;
      r_op_req <= 1'b0;
      r_op_dbl <= 1'b0;
      r_op_xa  <= '0;
      r_op_ya  <= '0;
      r_op_xb  <= '0;
      r_op_yb  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_acc) begin
            r_k     <= c;
            r_px    <= x1;
            r_py    <= y1;
            r_mode  <= mode;
            r_idx   <= IW'(K_BITS - 1);
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_kbit) begin
            r_init <= (r_mode == MODE_LADDER);
            r_more <= (r_idx != '0);
            r_idx  <= (r_idx != '0) ? r_idx - 1'b1 : '0;
            if (r_mode == MODE_DA && r_idx == '0) begin
              r_phase <= 1'b1;
              r_state <= ST_NEXT;
            end else begin
              r_phase <= 1'b0;
              r_state <= ST_OP_REQ;
            end
          end else if (r_idx == '0) begin
            r_x3    <= '0;
            r_y3    <= '0;
            r_inf   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        ST_OP_REQ: begin
          if (w_skip) begin
            r_state <= ST_NEXT;
          end else if (w_bypass) begin
            r_state <= ST_BYPASS;
          end else begin
            r_op_req <= 1'b1;
            r_op_dbl <= w_dbl;
            r_op_xa  <= w_ax;
            r_op_ya  <= w_ay;
            r_op_xb  <= w_bx;
            r_op_yb  <= w_by;
            r_state  <= ST_OP_WAIT;
          end
        end
        ST_OP_WAIT: begin
          if (w_ack_taken) begin
            r_op_req <= 1'b0;
            r_state  <= ST_NEXT;
          end
        end
        ST_BYPASS: begin
          r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (w_last) begin
            r_x3    <= r_r0x;
            r_y3    <= r_r0y;
            r_inf   <= r_r0inf;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_init  <= 1'b0;
            r_state <= ST_DONE;
          end else if (r_init) begin
            r_init  <= 1'b0;
            r_state <= ST_OP_REQ;
          end else if (!r_phase) begin
            r_phase <= 1'b1;
            r_state <= ST_OP_REQ;
          end else begin
            r_phase <= 1'b0;
            r_idx   <= r_idx - 1'b1;
            r_state <= ST_OP_REQ;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ECC_OP_COUNT_EN
  logic [15:0] r_op_count;

  // Count completed point ops per run, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op_count <= '0;
    end else if (w_start_acc) begin
      r_op_count <= '0;
    end else if (w_ack_taken && r_op_count != 16'hFFFF) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign op_count = r_op_count;
`endif

  assign busy   = r_busy;
  assign done   = r_done;
  assign x3     = r_x3;
  assign y3     = r_y3;
  assign inf    = r_inf;
  assign op_req = r_op_req;
  assign op_dbl = r_op_dbl;
  assign op_xa  = r_op_xa;
  assign op_ya  = r_op_ya;
  assign op_xb  = r_op_xb;
  assign op_yb  = r_op_yb;

endmodule

// File: tb/tb_ecc_scalar_mult_seq.sv
// tb_ecc_scalar_mult_seq: directed bench on y^2 = x^3 + 2x + 2 mod 17, P = (5,1).
// A behavioural point-op unit answers requests after a 1-8 cycle delay.
module tb_ecc_scalar_mult_seq;

  localparam int N      = 530;
  localparam int K_BITS = 530;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              mode  = 1'b0;
  logic [K_BITS-1:0] c     = '0;
  logic [N-1:0]      x1    = '0;
  logic [N-1:0]      y1    = '0;
  logic              busy, done, inf, op_req, op_dbl;
  logic [N-1:0]      x3, y3, op_xa, op_ya, op_xb, op_yb;
  logic              op_ack;
  logic [N-1:0]      op_xr, op_yr;
  logic              op_inf;
`ifdef ECC_OP_COUNT_EN
  logic [15:0]       opCountOut;
`endif

  int assertCount = 0;
  int failCount   = 0;
  int modelOps    = 0;
  int fixedDelay  = 0;

  ecc_scalar_mult_seq #(.N(N), .K_BITS(K_BITS)) dut (
`ifdef ECC_OP_COUNT_EN
    .op_count (opCountOut),
`endif
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .c      (c),
    .x1     (x1),
    .y1     (y1),
    .busy   (busy),
    .done   (done),
    .x3     (x3),
    .y3     (y3),
    .inf    (inf),
    .op_req (op_req),
    .op_dbl (op_dbl),
    .op_xa  (op_xa),
    .op_ya  (op_ya),
    .op_xb  (op_xb),
    .op_yb  (op_yb),
    .op_ack (op_ack),
    .op_xr  (op_xr),
    .op_yr  (op_yr),
    .op_inf (op_inf)
  );

  always #5 clk = ~clk;

  function automatic int modInv(input int a);
    for (int i = 1; i < 17; i++) begin
      if ((a * i) % 17 == 1) return i;
    end
    return 0;
  endfunction

  // Behavioural point add/double unit mod 17 with infinity detection.
  initial begin : opModel
    int d, xa, ya, xb, yb, xr, yr, lam, num, den;
    bit rinf;
    op_ack = 1'b0;
    op_xr  = '0;
    op_yr  = '0;
    op_inf = 1'b0;
    forever begin
      @(negedge clk);
      if (op_req && reset) begin
        xa = int'(op_xa[7:0]);
        ya = int'(op_ya[7:0]);
        xb = int'(op_xb[7:0]);
        yb = int'(op_yb[7:0]);
        rinf = 1'b0;
        num = 0;
        den = 1;
        if (op_dbl) begin
          xb = xa;
          yb = ya;
        end
        if (xa == xb && ya == yb) begin
          if (ya == 0) rinf = 1'b1;
          else begin
            num = (3 * xa * xa + 2) % 17;
            den = (2 * ya) % 17;
          end
        end else if (xa == xb) begin
          rinf = 1'b1;
        end else begin
          num = (yb - ya + 17) % 17;
          den = (xb - xa + 17) % 17;
        end
        if (rinf) begin
          xr = 0;
          yr = 0;
        end else begin
          lam = (num * modInv(den)) % 17;
          xr  = (lam * lam + 34 - xa - xb) % 17;
          yr  = (lam * ((xa - xr + 17) % 17) + 17 - ya) % 17;
        end
        d = (fixedDelay > 0) ? fixedDelay : int'($urandom_range(1, 8));
        repeat (d - 1) @(negedge clk);
        op_xr      = '0;
        op_yr      = '0;
        op_xr[7:0] = 8'(xr);
        op_yr[7:0] = 8'(yr);
        op_inf     = rinf;
        op_ack     = 1'b1;
        modelOps++;
        @(negedge clk);
        op_ack = 1'b0;
      end
    end
  end

  task automatic checkVal(input string tag, input logic [N-1:0] observed, input logic [N-1:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic m, input int k);
    modelOps = 0;
    @(negedge clk);
    mode      = m;
    c         = '0;
    c[31:0]   = k;
    x1        = '0;
    x1[7:0]   = 8'd5;
    y1        = '0;
    y1[7:0]   = 8'd1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    bit seen;
    seen = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkVal({tag, "_done_in_time"}, N'(seen), N'(1));
  endtask

  task automatic checkOutput(input string tag, input int ex, input int ey, input bit einf, input int eops);
    checkVal({tag, "_inf"}, inf, einf);
    if (ex >= 0) begin
      checkVal({tag, "_x3"}, x3, ex);
      checkVal({tag, "_y3"}, y3, ey);
    end
    checkVal({tag, "_busy"}, busy, 0);
    if (eops >= 0) begin
      checkVal({tag, "_ops"}, modelOps, eops);
`ifdef ECC_OP_COUNT_EN
      checkVal({tag, "_op_count"}, opCountOut, eops);
`endif
    end
  endtask

  initial begin : stimulus
    bit seen;
    $display("[TB] start");
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("rst_x3", x3, 0);
    checkVal("rst_y3", y3, 0);
    checkVal("rst_inf", inf, 0);
    checkVal("rst_busy", busy, 0);
    checkVal("rst_done", done, 0);
    checkVal("rst_op_req", op_req, 0);
    checkVal("rst_op_dbl", op_dbl, 0);
    checkVal("rst_op_xa", op_xa, 0);
    checkVal("rst_op_yb", op_yb, 0);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(1'b0, 0);
    checkVal("k0da_busy_after_start", busy, 1);
    checkVal("k0da_done_after_start", done, 0);
    waitDone("k0da");
    checkOutput("k0da", 0, 0, 1'b1, 0);
    applyStimulus(1'b1, 0);
    waitDone("k0lad");
    checkOutput("k0lad", 0, 0, 1'b1, 0);

    applyStimulus(1'b0, 1);
    waitDone("k1da");
    checkOutput("k1da", 5, 1, 1'b0, 0);
    applyStimulus(1'b1, 1);
    waitDone("k1lad");
    checkOutput("k1lad", 5, 1, 1'b0, 1);

    applyStimulus(1'b0, 16);
    waitDone("k16da");
    checkOutput("k16da", 10, 11, 1'b0, 4);
    applyStimulus(1'b1, 16);
    waitDone("k16lad");
    checkOutput("k16lad", 10, 11, 1'b0, 9);

    applyStimulus(1'b0, 9);
    waitDone("k9da");
    checkOutput("k9da", 7, 6, 1'b0, 4);
    applyStimulus(1'b1, 9);
    waitDone("k9lad");
    checkOutput("k9lad", 7, 6, 1'b0, 7);

    applyStimulus(1'b0, 19);
    waitDone("k19da");
    checkOutput("k19da", -1, -1, 1'b1, 6);
    applyStimulus(1'b1, 19);
    waitDone("k19lad");
    checkOutput("k19lad", -1, -1, 1'b1, 9);

    applyStimulus(1'b0, 39);
    waitDone("k39da");
    checkOutput("k39da", 5, 1, 1'b0, 6);
    applyStimulus(1'b1, 39);
    waitDone("k39lad");
    checkOutput("k39lad", 5, 1, 1'b0, 10);

    applyStimulus(1'b0, 16);
    repeat (20) @(negedge clk);
    mode     = 1'b1;
    c        = '0;
    c[31:0]  = 9;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("busy_start");
    checkOutput("busy_start", 10, 11, 1'b0, 4);

    fixedDelay = 10;
    applyStimulus(1'b0, 16);
    seen = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (op_req) begin
        seen = 1'b1;
        break;
      end
    end
    checkVal("abort_req_seen", N'(seen), N'(1));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkVal("abort_busy", busy, 0);
    checkVal("abort_done", done, 0);
    checkVal("abort_op_req", op_req, 0);
    checkVal("abort_x3", x3, 0);
    checkVal("abort_y3", y3, 0);
    checkVal("abort_inf", inf, 0);
    checkVal("abort_op_xa", op_xa, 0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (modelOps != 0) begin
        seen = 1'b1;
        break;
      end
    end
    checkVal("late_ack_seen", N'(seen), N'(1));
    @(negedge clk);
    checkVal("late_ack_busy", busy, 0);
    checkVal("late_ack_done", done, 0);
    checkVal("late_ack_x3", x3, 0);
    checkVal("late_ack_op_req", op_req, 0);
    fixedDelay = 0;

    applyStimulus(1'b0, 16);
    waitDone("rerun");
    checkOutput("rerun", 10, 11, 1'b0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
